instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, IR register and a two-state fetch FSM.
// Optional memory-timeout watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic [1:0]  PCSource,
  input  logic [15:0] ALUResult,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] IR,
  output logic [3:0]  op,
  output logic [15:0] PC,
  output logic        Ready,
  output logic        FetchFault,
  output logic        fetch_state
);

  // Handshake: mem_req is high for every FETCH cycle and mem_addr is held
  // constant; the word is taken on the first rising edge where mem_ack is high.
  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        fetch_start;
  logic        fetch_done;
  logic        timeout_hit;
  logic [15:0] fetch_addr;
  logic [15:0] pc_nxt;

  // State register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (IRWrite) state_nxt = FETCH;
      FETCH:   if (mem_ack || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    mem_req     = 1'b0;
    fetch_start = 1'b0;
    fetch_done  = 1'b0;
    case (state)
      IDLE:  fetch_start = IRWrite;
      FETCH: begin
        mem_req    = 1'b1;
        fetch_done = mem_ack;
      end
      default: mem_req = 1'b0;
    endcase
  end

  assign fetch_state = state;
  assign mem_addr    = fetch_addr;
  assign op          = IR[15:12];

  // The jump form uses the IR value that was present before this edge.
  always_comb begin
    pc_nxt = PC;
    case (PCSource)
      2'b00:   pc_nxt = PC + 16'd1;
      2'b01:   pc_nxt = ALUResult;
      2'b10:   pc_nxt = {PC[15:12], IR[11:0]};
      default: pc_nxt = PC;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)       PC <= 16'h0000;
    else if (PCWrite) PC <= pc_nxt;
  end

  // Fetch address captures the pre-edge PC, so a same-cycle PC write
  // does not affect the fetch being started.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)           fetch_addr <= 16'h0000;
    else if (fetch_start) fetch_addr <= PC;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)          IR <= 16'h0000;
    else if (fetch_done) IR <= mem_rdata;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)           Ready <= 1'b0;
    else if (fetch_start) Ready <= 1'b0;
    else if (fetch_done)  Ready <= 1'b1;
  end

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] timeout_cnt;
  logic       fault_q;

  // Fires on the 255th FETCH cycle without an acknowledge.
  assign timeout_hit = (state == FETCH) && !mem_ack && (timeout_cnt == 8'd254);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)                          timeout_cnt <= 8'd0;
    else if (fetch_start)                timeout_cnt <= 8'd0;
    else if ((state == FETCH) && !mem_ack) timeout_cnt <= timeout_cnt + 8'd1;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)           fault_q <= 1'b0;
    else if (fetch_start) fault_q <= 1'b0;
    else if (timeout_hit) fault_q <= 1'b1;
  end

  assign FetchFault = fault_q;
`else
  assign timeout_hit = 1'b0;
  assign FetchFault  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with an IR scoreboard queue.
// Define FETCH_TIMEOUT_EN to exercise the timeout watchdog path.
module tb_instr_fetch_unit;

  logic        CLK;
  logic        Reset;
  logic        IRWrite;
  logic        PCWrite;
  logic [1:0]  PCSource;
  logic [15:0] ALUResult;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] IR;
  logic [3:0]  op;
  logic [15:0] PC;
  logic        Ready;
  logic        FetchFault;
  logic        fetch_state;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_pc;
  logic [15:0] model_ir;

  instr_fetch_unit dut (
    .CLK(CLK), .Reset(Reset), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSource(PCSource), .ALUResult(ALUResult), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .IR(IR), .op(op), .PC(PC), .Ready(Ready), .FetchFault(FetchFault),
    .fetch_state(fetch_state)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] pc_model(input logic [15:0] pc, input logic [15:0] ir,
                                           input logic [1:0] src, input logic [15:0] alu);
    case (src)
      2'b00:   return pc + 16'd1;
      2'b01:   return alu;
      2'b10:   return {pc[15:12], ir[11:0]};
      default: return pc;
    endcase
  endfunction

  task automatic pc_write(input logic [1:0] src, input logic [15:0] alu);
    PCWrite = 1'b1; PCSource = src; ALUResult = alu;
    model_pc = pc_model(model_pc, model_ir, src, alu);
    step();
    PCWrite = 1'b0;
    check("pc_write", PC, model_pc);
  endtask

  // Full fetch: IRWrite (optionally with a same-cycle PC write), a number of
  // un-acked FETCH cycles with redundant IRWrite pulses, then the ack.
  task automatic fetch(input logic [15:0] data, input int waits, input logic start_pcw,
                       input logic [1:0] start_src, input logic [15:0] start_alu,
                       input logic bump);
    logic [15:0] exp_addr;
    logic [15:0] got_ir;
    exp_addr = model_pc;
    IRWrite = 1'b1;
    PCWrite = start_pcw; PCSource = start_src; ALUResult = start_alu;
    if (start_pcw) model_pc = pc_model(model_pc, model_ir, start_src, start_alu);
    exp_q.push_back(data);
    step();
    IRWrite = 1'b0; PCWrite = 1'b0;
    check("fetch_req", {15'd0, mem_req}, 16'd1);
    check("fetch_addr", mem_addr, exp_addr);
    check("fetch_state", {15'd0, fetch_state}, 16'd1);
    check("fetch_pc", PC, model_pc);
    for (int i = 0; i < waits; i++) begin
      IRWrite = 1'b1;
      PCWrite = bump; PCSource = 2'b00;
      if (bump) model_pc = model_pc + 16'd1;
      step();
      IRWrite = 1'b0; PCWrite = 1'b0;
      check("wait_addr", mem_addr, exp_addr);
      check("wait_req", {15'd0, mem_req}, 16'd1);
      check("wait_ready", {15'd0, Ready}, 16'd0);
    end
    mem_ack = 1'b1; mem_rdata = data;
    step();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    check("done_ready", {15'd0, Ready}, 16'd1);
    check("done_req", {15'd0, mem_req}, 16'd0);
    check("done_pc", PC, model_pc);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty got=0 exp=1");
    end else begin
      got_ir = exp_q.pop_front();
      check("done_ir", IR, got_ir);
      check("done_op", {12'd0, op}, {12'd0, got_ir[15:12]});
      model_ir = got_ir;
    end
  endtask

  initial begin
    Reset = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0; PCSource = 2'b11;
    ALUResult = 16'h0000; mem_ack = 1'b0; mem_rdata = 16'h0000;
    model_pc = 16'h0000; model_ir = 16'h0000;
    #12;
    check("rst_pc", PC, 16'h0000);
    check("rst_ir", IR, 16'h0000);
    check("rst_op", {12'd0, op}, 16'h0000);
    check("rst_req", {15'd0, mem_req}, 16'd0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_ready", {15'd0, Ready}, 16'd0);
    check("rst_fault", {15'd0, FetchFault}, 16'd0);
    step();
    Reset = 1'b1;
    step();

    // Basic two-cycle fetch
    fetch(16'h3A5C, 0, 1'b0, 2'b11, 16'h0000, 1'b0);

    // Ack while idle has no effect and Ready persists
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    check("idle_ack_ir", IR, model_ir);
    check("idle_ack_ready", {15'd0, Ready}, 16'd1);
    check("idle_ack_req", {15'd0, mem_req}, 16'd0);

    // PC sources: wrap, jump form, hold
    pc_write(2'b01, 16'hFFFF);
    pc_write(2'b00, 16'h0000);
    check("pc_wrap", PC, 16'h0000);
    pc_write(2'b01, 16'h1234);
    pc_write(2'b10, 16'h0000);
    check("pc_jump", PC, 16'h1A5C);
    pc_write(2'b11, 16'hBEEF);

    // Same-cycle fetch and PC write: fetch uses the old PC
    pc_write(2'b01, 16'h0010);
    fetch(16'h7001, 0, 1'b1, 2'b01, 16'h0200, 1'b0);
    check("concurrent_pc", PC, 16'h0200);

    // Five un-acked cycles with IRWrite pulses and PC increments
    fetch(16'hC0DE, 5, 1'b0, 2'b11, 16'h0000, 1'b1);
    check("single_fetch_q", exp_q.size(), 16'd0);

    // Random fetches
    for (int n = 0; n < 6; n++) begin
      fetch(16'($urandom_range(0, 65535)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    end

    // Reset mid-fetch aborts; a late ack is ignored
    IRWrite = 1'b1;
    step();
    IRWrite = 1'b0;
    check("abort_req_pre", {15'd0, mem_req}, 16'd1);
    #2;
    Reset = 1'b0;
    #1;
    model_pc = 16'h0000; model_ir = 16'h0000;
    check("abort_req", {15'd0, mem_req}, 16'd0);
    check("abort_ir", IR, 16'h0000);
    check("abort_ready", {15'd0, Ready}, 16'd0);
    check("abort_pc", PC, 16'h0000);
    step();
    Reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    step();
    mem_ack = 1'b0;
    check("abort_ack_ir", IR, 16'h0000);
    check("abort_ack_ready", {15'd0, Ready}, 16'd0);
    check("abort_ack_req", {15'd0, mem_req}, 16'd0);

`ifdef FETCH_TIMEOUT_EN
    IRWrite = 1'b1;
    step();
    IRWrite = 1'b0;
    for (int i = 0; i < 254; i++) step();
    check("to_req_pre", {15'd0, mem_req}, 16'd1);
    check("to_fault_pre", {15'd0, FetchFault}, 16'd0);
    step();
    check("to_fault", {15'd0, FetchFault}, 16'd1);
    check("to_req", {15'd0, mem_req}, 16'd0);
    check("to_ready", {15'd0, Ready}, 16'd0);
    check("to_ir", IR, model_ir);
    IRWrite = 1'b1;
    step();
    IRWrite = 1'b0;
    check("to_fault_clr", {15'd0, FetchFault}, 16'd0);
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    step();
    mem_ack = 1'b0;
    check("to_recover_ir", IR, 16'h5555);
`else
    IRWrite = 1'b1;
    step();
    IRWrite = 1'b0;
    for (int i = 0; i < 300; i++) step();
    check("long_req", {15'd0, mem_req}, 16'd1);
    check("long_fault", {15'd0, FetchFault}, 16'd0);
    check("long_ready", {15'd0, Ready}, 16'd0);
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    step();
    mem_ack = 1'b0;
    check("long_ir", IR, 16'h5555);
    check("long_done_ready", {15'd0, Ready}, 16'd1);
`endif

    check("sb_drained", exp_q.size(), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
